conv_seq_ctrl: RTL and testbench

- Autonomous sequencer for the 3x3 convolution accelerator. It is the accelerator's sole bus master.
- Loads the kernel once from shared memory, then slides the 3x3 window over a WxH image. For each position it loads 9 window words, pulses start, polls status, reads the result and writes it to an output buffer.
- The CPU configures and launches it through a word-addressed register port. The sequencer sits between the CPU bus decoder, a 1-cycle-latency data RAM, and the accelerator.

---
 rtl/conv_seq_ctrl_if.sv | 36 +++
 rtl/conv_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_ctrl_if.sv
// Bus bundle for conv_seq_ctrl: CPU register port, data-RAM read port, accelerator port, output buffer.
// master = sequencer side, slave = surrounding system (CPU decoder, RAM, accelerator, output buffer).
interface conv_seq_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [5:0]    addr;
    logic          en;
    logic          we;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata;
    logic [5:0]    acc_addr;
    logic          acc_en;
    logic          acc_we;
    logic [DW-1:0] acc_din;
    logic [DW-1:0] acc_dout;
    logic [AW-1:0] out_addr;
    logic          out_we;
    logic [DW-1:0] out_wdata;
    logic          irq;

    modport master (
        input  addr, en, we, din, mem_rdata, acc_dout,
        output dout, mem_addr, mem_rd_en, acc_addr, acc_en, acc_we, acc_din,
               out_addr, out_we, out_wdata, irq
    );

    modport slave (
        output addr, en, we, din, mem_rdata, acc_dout,
        input  dout, mem_addr, mem_rd_en, acc_addr, acc_en, acc_we, acc_din,
               out_addr, out_we, out_wdata, irq
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: autonomous 3x3 convolution sequencer; optional ReLU output stage via CONV_SEQ_RELU_EN.
// Latency 18 cycles kernel load + 23 cycles per output pixel; no backpressure (RAM fixed 1-cycle read, accelerator polled).
module conv_seq_ctrl #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    conv_seq_ctrl_if.master bus
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_KRD  = 4'd1;
    localparam logic [3:0] S_KWR  = 4'd2;
    localparam logic [3:0] S_WRD  = 4'd3;
    localparam logic [3:0] S_WWR  = 4'd4;
    localparam logic [3:0] S_STRT = 4'd5;
    localparam logic [3:0] S_POLL = 4'd6;
    localparam logic [3:0] S_RES  = 4'd7;
    localparam logic [3:0] S_FIN  = 4'd8;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h01;
    localparam logic [5:0] A_IMG    = 6'h02;
    localparam logic [5:0] A_KER    = 6'h03;
    localparam logic [5:0] A_OUT    = 6'h04;
    localparam logic [5:0] A_DIMS   = 6'h05;
    localparam logic [5:0] A_PIX    = 6'h06;

    logic [DW-1:0] res_val;
`ifdef CONV_SEQ_RELU_EN
    localparam logic FEAT_RELU = 1'b1;
    assign res_val = bus.acc_dout[DW-1] ? '0 : bus.acc_dout;
`else
    localparam logic FEAT_RELU = 1'b0;
    assign res_val = bus.acc_dout;
`endif

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] img_base_q, img_base_d;
    logic [AW-1:0] ker_base_q, ker_base_d;
    logic [AW-1:0] out_base_q, out_base_d;
    logic [7:0]    w_q, w_d, h_q, h_d;
    logic [DW-1:0] pix_cnt_q, pix_cnt_d;
    logic          done_q, done_d, err_q, err_d;
    logic [1:0]    kr_q, kr_d, kc_q, kc_d;
    logic [7:0]    r_q, r_d, c_q, c_d;
    logic [1:0]    poll_q, poll_d;

    logic          busy, wr, start_req, abort_req, cfg_wr, dims_ok;
    logic          word_last, pos_last;
    logic [1:0]    kr_nx, kc_nx;
    logic [3:0]    k_idx;
    logic [8:0]    row_w, col_w;
    logic [31:0]   win_off;
    logic          unused_din;

    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign wr        = bus.en && bus.we;
    assign abort_req = wr && (bus.addr == A_CTRL) && bus.din[1];
    assign start_req = wr && (bus.addr == A_CTRL) && bus.din[0] && !bus.din[1];
    assign cfg_wr    = wr && !busy;
    assign dims_ok   = (w_q >= 8'd3) && (h_q >= 8'd3);
    assign unused_din = ^bus.din[DW-1:16];

    // Window word k = 3*kr + kc; both loads walk kr/kc in the same row-major order.
    assign k_idx     = {1'b0, kr_q, 1'b0} + {2'b00, kr_q} + {2'b00, kc_q};
    assign word_last = (kr_q == 2'd2) && (kc_q == 2'd2);
    assign kc_nx     = (kc_q == 2'd2) ? 2'd0 : kc_q + 2'd1;
    assign kr_nx     = (kc_q != 2'd2) ? kr_q : ((kr_q == 2'd2) ? 2'd0 : kr_q + 2'd1);
    assign pos_last  = (r_q == h_q - 8'd3) && (c_q == w_q - 8'd3);
    assign row_w     = {1'b0, r_q} + {7'b0, kr_q};
    assign col_w     = {1'b0, c_q} + {7'b0, kc_q};
    assign win_off   = 32'(row_w) * 32'(w_q) + 32'(col_w);

    always_comb begin
        state_d    = state_q;
        img_base_d = img_base_q;
        ker_base_d = ker_base_q;
        out_base_d = out_base_q;
        w_d        = w_q;
        h_d        = h_q;
        pix_cnt_d  = pix_cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        r_d        = r_q;
        c_d        = c_q;
        poll_d     = poll_q;

        if (cfg_wr) begin
            case (bus.addr)
                A_IMG:   img_base_d = bus.din[AW-1:0];
                A_KER:   ker_base_d = bus.din[AW-1:0];
                A_OUT:   out_base_d = bus.din[AW-1:0];
                A_DIMS: begin
                    w_d = bus.din[7:0];
                    h_d = bus.din[15:8];
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start_req) begin
                    pix_cnt_d = '0;
                    kr_d      = 2'd0;
                    kc_d      = 2'd0;
                    r_d       = 8'd0;
                    c_d       = 8'd0;
                    if (dims_ok) begin
                        state_d = S_KRD;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_KRD: state_d = S_KWR;
            S_KWR: begin
                kr_d    = kr_nx;
                kc_d    = kc_nx;
                state_d = word_last ? S_WRD : S_KRD;
            end
            S_WRD: state_d = S_WWR;
            S_WWR: begin
                kr_d    = kr_nx;
                kc_d    = kc_nx;
                state_d = word_last ? S_STRT : S_WRD;
            end
            S_STRT: begin
                poll_d  = 2'd0;
                state_d = S_POLL;
            end
            // The first two polls may still see the previous pixel's done bit.
            S_POLL: begin
                if (poll_q != 2'd2)
                    poll_d = poll_q + 2'd1;
                else if (bus.acc_dout[1:0] == 2'b10)
                    state_d = S_RES;
            end
            S_RES: begin
                pix_cnt_d = pix_cnt_q + DW'(1);
                if (c_q == w_q - 8'd3) begin
                    c_d = 8'd0;
                    r_d = r_q + 8'd1;
                end else begin
                    c_d = c_q + 8'd1;
                end
                if (pos_last) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WRD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_req && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            img_base_q <= '0;
            ker_base_q <= '0;
            out_base_q <= '0;
            w_q        <= '0;
            h_q        <= '0;
            pix_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            kr_q       <= '0;
            kc_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            poll_q     <= '0;
        end else begin
            state_q    <= state_d;
            img_base_q <= img_base_d;
            ker_base_q <= ker_base_d;
            out_base_q <= out_base_d;
            w_q        <= w_d;
            h_q        <= h_d;
            pix_cnt_q  <= pix_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            r_q        <= r_d;
            c_q        <= c_d;
            poll_q     <= poll_d;
        end
    end

    always_comb begin
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        bus.acc_en    = 1'b0;
        bus.acc_we    = 1'b0;
        bus.acc_addr  = 6'h00;
        bus.acc_din   = '0;
        bus.out_we    = 1'b0;
        bus.out_addr  = '0;
        bus.out_wdata = '0;
        case (state_q)
            S_KRD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = ker_base_q + AW'(k_idx);
            end
            S_WRD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = img_base_q + win_off[AW-1:0];
            end
            S_KWR, S_WWR: begin
                bus.acc_en   = 1'b1;
                bus.acc_we   = 1'b1;
                bus.acc_addr = ((state_q == S_KWR) ? 6'h10 : 6'h20) + {2'b00, k_idx};
                bus.acc_din  = bus.mem_rdata;
            end
            S_STRT: begin
                bus.acc_en  = 1'b1;
                bus.acc_we  = 1'b1;
                bus.acc_din = DW'(1);
            end
            S_POLL: begin
                bus.acc_en   = 1'b1;
                bus.acc_addr = 6'h01;
            end
            S_RES: begin
                bus.acc_en    = 1'b1;
                bus.acc_addr  = 6'h02;
                bus.out_we    = 1'b1;
                bus.out_addr  = out_base_q + pix_cnt_q[AW-1:0];
                bus.out_wdata = res_val;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.dout = '0;
        if (bus.en && !bus.we) begin
            case (bus.addr)
                A_STATUS: bus.dout = DW'({FEAT_RELU, err_q, done_q, busy});
                A_IMG:    bus.dout = DW'(img_base_q);
                A_KER:    bus.dout = DW'(ker_base_q);
                A_OUT:    bus.dout = DW'(out_base_q);
                A_DIMS:   bus.dout = DW'({h_q, w_q});
                A_PIX:    bus.dout = pix_cnt_q;
                default:  bus.dout = '0;
            endcase
        end
    end

    assign bus.irq = done_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl with RAM and accelerator models, scoreboarded output buffer writes.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;
    localparam int AW = 16;
    localparam int DW = 32;
`ifdef CONV_SEQ_RELU_EN
    localparam logic [31:0] FEAT = 32'd8;
`else
    localparam logic [31:0] FEAT = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.AW(AW), .DW(DW)) bus ();
    conv_seq_ctrl #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed { logic [15:0] a; logic [31:0] d; } exp_t;
    exp_t  sb_q[$];
    exp_t  mon_e;
    int    n_checks = 0;
    int    n_pass = 0;
    int    act_cnt = 0;
    int    cyc_cnt = 0;
    logic [31:0] mem [0:65535];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // RAM: 1-cycle read latency
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

    // Accelerator: done stays stale one cycle after start, result ready on the third poll
    logic [31:0] acc_reg [0:63];
    logic        acc_busy, acc_done;
    logic [31:0] acc_res;
    int          acc_phase;
    function automatic logic [31:0] acc_conv();
        logic [31:0] s = 0;
        for (int k = 0; k < 9; k++) s += acc_reg[16 + k] * acc_reg[32 + k];
        return s;
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_busy <= 1'b0; acc_done <= 1'b0; acc_res <= 0; acc_phase <= 0;
        end else begin
            if (bus.acc_en && bus.acc_we) acc_reg[bus.acc_addr] <= bus.acc_din;
            if (bus.acc_en && bus.acc_we && bus.acc_addr == 6'h00 && bus.acc_din[0]) acc_phase <= 1;
            else if (acc_phase == 1) begin acc_done <= 1'b0; acc_busy <= 1'b1; acc_phase <= 2; end
            else if (acc_phase == 2) begin
                acc_res <= acc_conv(); acc_done <= 1'b1; acc_busy <= 1'b0; acc_phase <= 0;
            end
        end
    end
    always_comb begin
        bus.acc_dout = '0;
        if (bus.acc_addr == 6'h01) bus.acc_dout = {30'b0, acc_done, acc_busy};
        else if (bus.acc_addr == 6'h02) bus.acc_dout = acc_res;
    end

    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        if (!rst && (bus.mem_rd_en || bus.acc_en)) act_cnt++;
        if (!rst && bus.out_we) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: write addr=%h data=%h with none expected", bus.out_addr, bus.out_wdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_addr", {16'b0, bus.out_addr}, {16'b0, mon_e.a});
                check("out_data", bus.out_wdata, mon_e.d);
            end
        end
    end

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk); bus.addr = a; bus.en = 1'b1; bus.we = 1'b1; bus.din = d;
        @(posedge clk); #1; bus.en = 1'b0; bus.we = 1'b0; bus.din = '0;
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk); bus.addr = a; bus.en = 1'b1; bus.we = 1'b0;
        #1; d = bus.dout; bus.en = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a; e.d = d;
        sb_q.push_back(e);
    endtask

    // Reference: plain sliding-window sum over the RAM contents, row-major output order
    task automatic push_model(input int w, input int h, input logic [15:0] ib, input logic [15:0] kb, input logic [15:0] ob);
        logic [31:0] s;
        int idx = 0;
        for (int r = 0; r < h - 2; r++)
            for (int c = 0; c < w - 2; c++) begin
                s = 0;
                for (int k = 0; k < 9; k++)
                    s += mem[16'(ib + (r + k / 3) * w + c + k % 3)] * mem[16'(kb + k)];
`ifdef CONV_SEQ_RELU_EN
                if (s[31]) s = 0;
`endif
                push_exp(16'(ob + idx), s);
                idx++;
            end
    endtask

    task automatic configure(input int w, input int h, input logic [15:0] ib, input logic [15:0] kb, input logic [15:0] ob);
        cpu_write(6'h02, {16'b0, ib});
        cpu_write(6'h03, {16'b0, kb});
        cpu_write(6'h04, {16'b0, ob});
        cpu_write(6'h05, 32'(h * 256 + w));
    endtask

    task automatic run(input int w, input int h);
        logic [31:0] v;
        int cyc = 0;
        int n = (w - 2) * (h - 2);
        cpu_write(6'h00, 32'd1);
        while (!bus.irq && cyc < 20000) begin @(posedge clk); #1; cyc++; end
        check("run_cycles", cyc, 32'(18 + 23 * n));
        cpu_read(6'h01, v); check("status_done", v, 32'd2 | FEAT);
        cpu_read(6'h06, v); check("pix_cnt", v, 32'(n));
        check("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic fill_rand(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) mem[16'(base + i)] = 32'($urandom_range(0, 255)) - 32'd128;
    endtask

    task automatic check_quiet(input string nm);
        check(nm, {27'b0, bus.mem_rd_en, bus.acc_en, bus.acc_we, bus.out_we, bus.irq}, 32'd0);
        check({nm, "_addr"}, {bus.mem_addr, bus.out_addr}, 32'd0);
        check({nm, "_acc"}, {26'b0, bus.acc_addr} | bus.acc_din | bus.out_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int n, t0;
        int w, h;
        logic [15:0] ib, kb, ob;
        bus.addr = '0; bus.en = 1'b0; bus.we = 1'b0; bus.din = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1; check_quiet("reset_outputs");
        @(negedge clk); rst = 1'b0;
        cpu_read(6'h01, v); check("reset_status", v, FEAT);
        cpu_read(6'h06, v); check("reset_pix", v, 32'd0);
        cpu_read(6'h05, v); check("reset_dims", v, 32'd0);

        // 3x3 image 1..9 with all-ones kernel
        for (int i = 0; i < 9; i++) begin mem[16'h0100 + i] = 32'(i + 1); mem[16'h0200 + i] = 32'd1; end
        configure(3, 3, 16'h0100, 16'h0200, 16'h0300);
        push_exp(16'h0300, 32'd45);
        run(3, 3);
        cpu_read(6'h00, v); check("ctrl_reads_zero", v, 32'd0);

        // 4x4 image 0..15 with center-only kernel
        for (int i = 0; i < 16; i++) mem[16'h1000 + i] = 32'(i);
        for (int i = 0; i < 9; i++) mem[16'h1100 + i] = (i == 4) ? 32'd1 : 32'd0;
        configure(4, 4, 16'h1000, 16'h1100, 16'h1200);
        push_exp(16'h1200, 32'd5); push_exp(16'h1201, 32'd6);
        push_exp(16'h1202, 32'd9); push_exp(16'h1203, 32'd10);
        run(4, 4);

        // all -1 kernel yields a negative result
        for (int i = 0; i < 9; i++) mem[16'h2000 + i] = 32'hFFFF_FFFF;
        configure(3, 3, 16'h0100, 16'h2000, 16'h2100);
`ifdef CONV_SEQ_RELU_EN
        push_exp(16'h2100, 32'd0);
`else
        push_exp(16'h2100, 32'hFFFF_FFD3);
`endif
        run(3, 3);

        // too-small dimensions: immediate error, no traffic
        cpu_write(6'h05, 32'h0000_0502);
        act_cnt = 0;
        cpu_write(6'h00, 32'd1);
        cpu_read(6'h01, v); check("small_dims_status", v, 32'd6 | FEAT);
        repeat (5) @(posedge clk);
        check("small_dims_traffic", 32'(act_cnt), 32'd0);
        cpu_read(6'h06, v); check("small_dims_pix", v, 32'd0);

        // abort mid-run; a second START and a config write while busy are ignored
        fill_rand(16'h4000, 25); fill_rand(16'h4100, 9);
        configure(5, 5, 16'h4000, 16'h4100, 16'h4200);
        push_model(5, 5, 16'h4000, 16'h4100, 16'h4200);
        cpu_write(6'h00, 32'd1);
        t0 = cyc_cnt;
        repeat (25) @(posedge clk);
        cpu_write(6'h00, 32'd1);
        cpu_write(6'h02, 32'h0000_1234);
        while (cyc_cnt - t0 < 55) @(posedge clk);
        cpu_write(6'h00, 32'd2);
        check_quiet("abort_outputs");
        cpu_read(6'h01, v); check("abort_status", v, 32'd4 | FEAT);
        cpu_read(6'h06, v); check("abort_pix", v, 32'd1);
        cpu_read(6'h02, v); check("busy_cfg_ignored", v, 32'h0000_4000);
        check("abort_remaining", 32'(sb_q.size()), 32'd8);
        sb_q.delete();
        cpu_write(6'h00, 32'd2);
        cpu_write(6'h00, 32'd3);
        cpu_read(6'h01, v); check("idle_abort_noop", v, 32'd4 | FEAT);

        // asynchronous reset during POLL
        configure(3, 3, 16'h0100, 16'h0200, 16'h0300);
        push_model(3, 3, 16'h0100, 16'h0200, 16'h0300);
        cpu_write(6'h00, 32'd1);
        n = 0;
        while (!(bus.acc_en && !bus.acc_we && bus.acc_addr == 6'h01) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("poll_reached", 32'(n < 200), 32'd1);
        #2 rst = 1'b1;
        #1 check_quiet("rst_mid_run");
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        cpu_read(6'h01, v); check("post_reset_status", v, FEAT);
        cpu_read(6'h06, v); check("post_reset_pix", v, 32'd0);

        // randomized runs, last one wrapping the output address
        for (int t = 0; t < 5; t++) begin
            w  = $urandom_range(3, 6);
            h  = $urandom_range(3, 6);
            ib = 16'($urandom_range(0, 65535));
            kb = ib + 16'h8000;
            ob = (t == 4) ? 16'hFFFE : 16'($urandom_range(0, 65535));
            fill_rand(ib, w * h);
            fill_rand(kb, 9);
            configure(w, h, ib, kb, ob);
            push_model(w, h, ib, kb, ob);
            run(w, h);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
